// File: rtl/switch_pkg.sv
// Shared switch-wide port count, port mask/index types and a round-robin helper.
package switch_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [NUM_PORTS-1:0] port_mask_t;
  typedef logic [PORT_W-1:0]    port_idx_t;

  // Successor of a port index, wrapping at NUM_PORTS (works for non power-of-two counts).
  function automatic port_idx_t next_idx(input port_idx_t i);
    return (int'(i) == NUM_PORTS - 1) ? '0 : port_idx_t'(int'(i) + 1);
  endfunction
endpackage

// File: rtl/egress_fwd_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of elig_i scanning upward from ptr_i.
module rr_priority_pick
  import switch_pkg::*;
(
  input  port_mask_t elig_i,
  input  port_idx_t  ptr_i,
  output port_idx_t  idx_o,
  output logic       found_o
);
  // Walk NUM_PORTS positions starting at the pointer; keep the first hit.
  always_comb begin
    port_idx_t p;
    idx_o   = '0;
    found_o = 1'b0;
    p       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = port_idx_t'((int'(ptr_i) + k) % NUM_PORTS);
      if (!found_o && elig_i[p]) begin
        found_o = 1'b1;
        idx_o   = p;
      end
    end
  end
endmodule

// File: rtl/egress_fwd_scheduler.sv
// Forwarding scheduler: round-robin grants of egress ports to ingress requests,
// egress held until TX done, aging with a single urgent reservation.
module egress_fwd_scheduler
  import switch_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic                        switch_clk,
  input  logic                        switch_rst,
  input  port_mask_t                  req_valid_i,
  input  port_mask_t [NUM_PORTS-1:0]  req_dst_mask_i,
  output port_mask_t                  grant_o,
  output logic                        grant_drop_o,
  output port_mask_t                  grant_mask_o,
  output port_mask_t                  egress_start_o,
  output port_idx_t  [NUM_PORTS-1:0]  egress_src_o,
  output port_mask_t                  egress_busy_o,
  input  port_mask_t                  egress_done_i,
  output logic                        protocol_err_o
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  typedef logic [WAIT_W-1:0] wait_t;
  localparam wait_t WAIT_SAT = wait_t'(MAX_WAIT);

  port_mask_t grant_q, grant_d, start_q, start_d, gmask_q, gmask_d;
  port_mask_t busy_q, busy_d, res_mask_q, res_mask_d, pend_q, pend_d;
  logic       drop_q, drop_d, err_q, err_d, res_vld_q, res_vld_d;
  port_idx_t  ptr_q, ptr_d, own_q, own_d;
  port_idx_t  [NUM_PORTS-1:0] src_q, src_d;
  port_mask_t [NUM_PORTS-1:0] last_mask_q, eff;
  wait_t      [NUM_PORTS-1:0] wait_q, wait_d;

  port_mask_t elig, urgent, chg, win_mask;
  port_idx_t  win_idx, urg_idx;
  logic       win_found, urg_found;

  // Effective masks, eligibility and mask-stability check, all from registered state.
  // A request in its grant cycle (grant_q) is already consumed and is ignored.
  always_comb begin
    eff  = '0;
    elig = '0;
    chg  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eff[i]  = req_dst_mask_i[i] & ~(port_mask_t'(1) << i);
      elig[i] = req_valid_i[i] && !grant_q[i] && ((eff[i] & busy_q) == '0) &&
                (((eff[i] & res_mask_q) == '0) || (res_vld_q && own_q == port_idx_t'(i)));
      chg[i]  = pend_q[i] && req_valid_i[i] && !grant_q[i] &&
                (req_dst_mask_i[i] != last_mask_q[i]);
    end
  end

  rr_priority_pick u_grant_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .idx_o  (win_idx),
    .found_o(win_found)
  );

  assign win_mask = eff[win_idx];

  // Saturated waiters that are not being granted right now are reservation candidates.
  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      urgent[i] = req_valid_i[i] && !grant_q[i] && (wait_q[i] == WAIT_SAT) &&
                  !(win_found && win_idx == port_idx_t'(i));
  end

  rr_priority_pick u_urgent_pick (
    .elig_i (urgent),
    .ptr_i  (ptr_q),
    .idx_o  (urg_idx),
    .found_o(urg_found)
  );

  // Next state: grant pulses and allocation, release, aging, reservation, error flag.
  always_comb begin
    grant_d    = '0;
    start_d    = '0;
    gmask_d    = '0;
    drop_d     = 1'b0;
    busy_d     = busy_q & ~egress_done_i;
    src_d      = src_q;
    ptr_d      = ptr_q;
    res_vld_d  = res_vld_q;
    own_d      = own_q;
    res_mask_d = res_mask_q;
    if (win_found) begin
      grant_d[win_idx] = 1'b1;
      gmask_d          = win_mask;
      drop_d           = (win_mask == '0);
      start_d          = win_mask;
      busy_d           = busy_d | win_mask;
      for (int j = 0; j < NUM_PORTS; j++)
        if (win_mask[j]) src_d[j] = win_idx;
      ptr_d = next_idx(win_idx);
    end
    // Owner's grant or withdraw frees the reservation; otherwise form one if urgent.
    if (res_vld_q) begin
      if ((win_found && win_idx == own_q) || !req_valid_i[own_q]) begin
        res_vld_d  = 1'b0;
        res_mask_d = '0;
      end
    end else if (urg_found) begin
      res_vld_d  = 1'b1;
      own_d      = urg_idx;
      res_mask_d = eff[urg_idx];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!req_valid_i[i] || grant_q[i] || (win_found && win_idx == port_idx_t'(i)))
        wait_d[i] = '0;
      else if (wait_q[i] == WAIT_SAT)
        wait_d[i] = wait_q[i];
      else
        wait_d[i] = wait_q[i] + wait_t'(1);
    end
    pend_d = req_valid_i & ~grant_q;
    err_d  = err_q | (|(egress_done_i & ~busy_q)) | (|chg);
  end

  // State registers; reset abandons every allocation immediately.
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      grant_q     <= '0;
      start_q     <= '0;
      gmask_q     <= '0;
      drop_q      <= 1'b0;
      busy_q      <= '0;
      src_q       <= '0;
      ptr_q       <= '0;
      res_vld_q   <= 1'b0;
      own_q       <= '0;
      res_mask_q  <= '0;
      wait_q      <= '0;
      pend_q      <= '0;
      last_mask_q <= '0;
      err_q       <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      start_q     <= start_d;
      gmask_q     <= gmask_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
      src_q       <= src_d;
      ptr_q       <= ptr_d;
      res_vld_q   <= res_vld_d;
      own_q       <= own_d;
      res_mask_q  <= res_mask_d;
      wait_q      <= wait_d;
      pend_q      <= pend_d;
      last_mask_q <= req_dst_mask_i;
      err_q       <= err_d;
    end
  end

  assign grant_o        = grant_q;
  assign grant_drop_o   = drop_q;
  assign grant_mask_o   = gmask_q;
  assign egress_start_o = start_q;
  assign egress_src_o   = src_q;
  assign egress_busy_o  = busy_q;
  assign protocol_err_o = err_q;
endmodule

// File: tb/tb_egress_fwd_scheduler.sv
// Scoreboard bench for egress_fwd_scheduler: directed scenarios plus random traffic.
module tb_egress_fwd_scheduler;
  import switch_pkg::*;
  localparam int MAX_WAIT = 64;
  localparam int MAXLEN   = 6;

  logic switch_clk = 1'b0;
  logic switch_rst = 1'b1;
  port_mask_t req_valid = '0;
  port_mask_t [NUM_PORTS-1:0] req_mask = '0;
  port_mask_t done = '0;
  port_mask_t grant, gmask, start, busy;
  port_idx_t [NUM_PORTS-1:0] src;
  logic drop, err;

  int vectors = 0;
  int miscompares = 0;

  egress_fwd_scheduler #(.MAX_WAIT(MAX_WAIT)) dut (
    .switch_clk    (switch_clk),
    .switch_rst    (switch_rst),
    .req_valid_i   (req_valid),
    .req_dst_mask_i(req_mask),
    .grant_o       (grant),
    .grant_drop_o  (drop),
    .grant_mask_o  (gmask),
    .egress_start_o(start),
    .egress_src_o  (src),
    .egress_busy_o (busy),
    .egress_done_i (done),
    .protocol_err_o(err)
  );

  always #5 switch_clk = ~switch_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int idx; port_mask_t mask; logic drop; int stamp; } exp_t;
  exp_t sb[$];
  port_mask_t m_busy, m_gprev, m_pend, m_rmask;
  port_mask_t m_last [NUM_PORTS];
  port_idx_t [NUM_PORTS-1:0] m_src;
  int m_wait [NUM_PORTS];
  int m_ptr, m_own, edge_n;
  logic m_err;

  task automatic model_reset();
    m_busy = '0; m_gprev = '0; m_pend = '0; m_rmask = '0; m_src = '0;
    m_ptr = 0; m_own = -1; edge_n = 0; m_err = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin m_wait[i] = 0; m_last[i] = '0; end
    sb.delete();
  endtask

  task automatic model_step();
    port_mask_t eff [NUM_PORTS];
    int win, urg, i;
    exp_t e;
    win = -1; urg = -1;
    for (int k = 0; k < NUM_PORTS; k++) eff[k] = req_mask[k] & ~(port_mask_t'(1) << k);
    // a request in its grant cycle is already accepted
    for (int k = 0; k < NUM_PORTS; k++) begin
      i = (m_ptr + k) % NUM_PORTS;
      if (win < 0 && req_valid[i] && !m_gprev[i] && (eff[i] & m_busy) == '0 &&
          ((eff[i] & m_rmask) == '0 || m_own == i)) win = i;
    end
    if (m_own < 0)
      for (int k = 0; k < NUM_PORTS; k++) begin
        i = (m_ptr + k) % NUM_PORTS;
        if (urg < 0 && i != win && req_valid[i] && !m_gprev[i] && m_wait[i] == MAX_WAIT) urg = i;
      end
    if ((done & ~m_busy) != '0) m_err = 1'b1;
    for (int k = 0; k < NUM_PORTS; k++)
      if (m_pend[k] && req_valid[k] && !m_gprev[k] && req_mask[k] != m_last[k]) m_err = 1'b1;
    m_busy = m_busy & ~done;
    if (m_own >= 0) begin
      if (win == m_own || !req_valid[m_own]) begin m_own = -1; m_rmask = '0; end
    end else if (urg >= 0) begin
      m_own = urg; m_rmask = eff[urg];
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!req_valid[k] || m_gprev[k] || win == k) m_wait[k] = 0;
      else if (m_wait[k] < MAX_WAIT) m_wait[k]++;
      m_pend[k] = req_valid[k] && !m_gprev[k];
      m_last[k] = req_mask[k];
    end
    m_gprev = '0;
    edge_n++;
    if (win >= 0) begin
      m_gprev[win] = 1'b1;
      m_busy = m_busy | eff[win];
      for (int j = 0; j < NUM_PORTS; j++) if (eff[win][j]) m_src[j] = port_idx_t'(win);
      m_ptr = (win + 1) % NUM_PORTS;
      e.idx = win; e.mask = eff[win]; e.drop = (eff[win] == '0); e.stamp = edge_n;
      sb.push_back(e);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge switch_clk or posedge switch_rst);
      if (switch_rst) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge switch_clk);
      if (!switch_rst) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("protocol_err", 32'(err), 32'(m_err));
        chk("egress_src", 32'(src), 32'(m_src));
        if (sb.size() > 0 && sb[0].stamp == edge_n) begin
          e = sb.pop_front();
          chk("grant", 32'(grant), 32'(port_mask_t'(1) << e.idx));
          chk("grant_mask", 32'(gmask), 32'(e.mask));
          chk("grant_drop", 32'(drop), 32'(e.drop));
          chk("egress_start", 32'(start), 32'(e.mask));
        end else begin
          chk("grant_idle", 32'(grant), 32'(0));
          chk("start_idle", 32'(start), 32'(0));
          chk("drop_idle", 32'(drop), 32'(0));
        end
      end
    end
  end

  // ---------------- stimulus agents ----------------
  int cnt [NUM_PORTS];
  port_mask_t auto_en = '0, fix_en = '0;
  port_mask_t fix_mask [NUM_PORTS];
  logic tx_auto = 1'b0, rand_len = 1'b0, wd_en = 1'b0;
  int tx_len = 10;
  int glog[$];

  function automatic port_mask_t rand_mask();
    case ($urandom_range(0, 3))
      0:       return '1;
      1, 2:    return port_mask_t'(1) << $urandom_range(0, NUM_PORTS - 1);
      default: return port_mask_t'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge switch_clk);
    #2;
    done = '0;
    for (int k = 0; k < NUM_PORTS; k++) if (grant[k]) glog.push_back(k);
    if (tx_auto)
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (start[j]) cnt[j] = rand_len ? int'($urandom_range(1, MAXLEN)) : tx_len;
        else if (cnt[j] > 0) begin
          cnt[j]--;
          if (cnt[j] == 0) done[j] = 1'b1;
        end
      end
    for (int i = 0; i < NUM_PORTS; i++)
      if (auto_en[i]) begin
        if (req_valid[i] && grant[i]) req_valid[i] = fix_en[i];
        else if (!req_valid[i]) begin
          if (fix_en[i] || $urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_mask[i]  = fix_en[i] ? fix_mask[i] : rand_mask();
          end
        end else if (wd_en && $urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
      end
  endtask

  task automatic apply_reset();
    @(posedge switch_clk);
    #5;
    switch_rst = 1'b1;
    done = '0;
    for (int j = 0; j < NUM_PORTS; j++) cnt[j] = 0;
    #1;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_drop", 32'(drop), 32'(0));
    chk("rst_gmask", 32'(gmask), 32'(0));
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_src", 32'(src), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    repeat (2) @(posedge switch_clk);
    #2 switch_rst = 1'b0;
  endtask

  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    int n;
    logic got;
    for (int j = 0; j < NUM_PORTS; j++) begin cnt[j] = 0; fix_mask[j] = '0; end
    apply_reset();

    // unicast on idle switch
    req_valid[0] = 1'b1; req_mask[0] = 4'b0010;
    step();
    chk("uni_grant", 32'(grant), 32'(4'b0001));
    chk("uni_mask", 32'(gmask), 32'(4'b0010));
    chk("uni_start", 32'(start), 32'(4'b0010));
    chk("uni_src1", 32'(src[1]), 32'(0));
    req_valid[0] = 1'b0; done = 4'b0010;
    step();
    chk("uni_release", 32'(busy[1]), 32'(0));

    // flood loses its own port, then a hairpin-only mask drops
    req_valid[2] = 1'b1; req_mask[2] = 4'b1111;
    step();
    chk("flood_grant", 32'(grant), 32'(4'b0100));
    chk("flood_mask", 32'(gmask), 32'(4'b1011));
    chk("flood_busy", 32'(busy), 32'(4'b1011));
    req_valid[2] = 1'b0; req_valid[3] = 1'b1; req_mask[3] = 4'b1000;
    step();
    chk("drop_grant", 32'(grant), 32'(4'b1000));
    chk("drop_flag", 32'(drop), 32'(1));
    chk("drop_start", 32'(start), 32'(0));
    req_valid[3] = 1'b0; done = 4'b1011;
    step();

    // round robin among 0,1,3 on egress 2, 10-cycle frames
    apply_reset();
    glog.delete();
    fix_mask[0] = 4'b0100; fix_mask[1] = 4'b0100; fix_mask[3] = 4'b0100;
    auto_en = 4'b1011; fix_en = 4'b1011; tx_auto = 1'b1; rand_len = 1'b0; tx_len = 10;
    n = 0;
    while (n < 200 && glog.size() < 6) begin step(); n++; end
    chk("rr_count", 32'(glog.size() >= 6), 32'(1));
    for (int k = 0; k < 6; k++) if (k < glog.size()) chk("rr_order", 32'(glog[k]), 32'(rr_exp[k]));
    auto_en = '0; fix_en = '0; req_valid = '0;
    repeat (12) step();

    // starvation guard: flood on 0 vs back-to-back unicasts from 1/2/3
    apply_reset();
    fix_mask[1] = 4'b0100; fix_mask[2] = 4'b1000; fix_mask[3] = 4'b0010;
    auto_en = 4'b1110; fix_en = 4'b1110; tx_auto = 1'b1; rand_len = 1'b1;
    repeat (20) step();
    req_valid[0] = 1'b1; req_mask[0] = 4'b1111;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      step(); n++;
      if (grant[0]) got = 1'b1;
      else if (n >= 66 && grant != '0 && (gmask & 4'b1110) != '0)
        chk("resv_leak", 32'(gmask & 4'b1110), 32'(0));
    end
    chk("starve_latency", 32'(got && n <= MAX_WAIT + MAXLEN + 3), 32'(1));
    req_valid[0] = 1'b0;
    auto_en = '0; fix_en = '0; req_valid = '0;
    repeat (10) step();

    // random traffic with withdraws
    apply_reset();
    auto_en = '1; fix_en = '0; wd_en = 1'b1; tx_auto = 1'b1; rand_len = 1'b1;
    repeat (3000) step();
    auto_en = '0; wd_en = 1'b0; req_valid = '0;
    repeat (20) step();

    // reset mid-operation with 3 egress busy and 2 requests pending
    apply_reset();
    tx_auto = 1'b0;
    req_valid[3] = 1'b1; req_mask[3] = 4'b1111;
    step();
    chk("mid_flood", 32'(grant), 32'(4'b1000));
    req_valid[3] = 1'b0;
    req_valid[0] = 1'b1; req_mask[0] = 4'b0010;
    req_valid[1] = 1'b1; req_mask[1] = 4'b0100;
    repeat (3) step();
    chk("mid_busy", 32'(busy), 32'(4'b0111));
    glog.delete();
    apply_reset();
    repeat (3) step();
    chk("rearb_n", 32'(glog.size()), 32'(2));
    if (glog.size() >= 2) begin
      chk("rearb_first", 32'(glog[0]), 32'(0));
      chk("rearb_second", 32'(glog[1]), 32'(1));
    end
    req_valid = '0;

    // protocol error: done on idle egress, then mask change while pending
    apply_reset();
    done = 4'b0100;
    step();
    chk("perr_set", 32'(err), 32'(1));
    chk("perr_nochange", 32'(busy), 32'(0));
    repeat (3) step();
    chk("perr_held", 32'(err), 32'(1));
    apply_reset();
    req_valid[0] = 1'b1; req_mask[0] = 4'b0100;
    step();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_mask[1] = 4'b0100;
    repeat (2) step();
    chk("mchg_clean", 32'(err), 32'(0));
    req_mask[1] = 4'b1000;
    repeat (2) step();
    chk("mchg_err", 32'(err), 32'(1));
    req_valid = '0;
    step();

    @(negedge switch_clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/egress_fwd_scheduler.md
Name: egress_fwd_scheduler

Overview:
- Forwarding scheduler between the ingress lookup stage and the per-port egress TX paths of the switch.
- Each ingress port presents one pending frame with its destination port mask:
  - one-hot for a learned unicast;
  - all ports for a flood.
- Grants egress ports to ingress requesters round-robin and holds each egress port until its TX path reports frame completion.
- Ages waiting requests, so a flood never starves behind a stream of unicasts.

Parameters:
NUM_PORTS, 4, number of switch ports (taken from switch_pkg)
MAX_WAIT, 64, cycles a request may wait before it becomes urgent and reserves its egress ports

Ports:
switch_clk  input  1  switch clock domain
switch_rst  input  1  reset; asynchronous assertion, active-high
req_valid_i  input  NUM_PORTS x 1  ingress i has a frame ready to forward
req_dst_mask_i  input  NUM_PORTS x NUM_PORTS  destination mask for ingress i
grant_o  output  NUM_PORTS x 1  one-cycle pulse: request i accepted
grant_drop_o  output  1  with grant_o: the effective mask was empty, frame is dropped
grant_mask_o  output  NUM_PORTS  effective egress mask of the granted request, valid with grant_o
egress_start_o  output  NUM_PORTS x 1  one-cycle pulse: egress j starts a frame
egress_src_o  output  NUM_PORTS x PORT_W  ingress index feeding egress j; held while busy
egress_busy_o  output  NUM_PORTS x 1  egress j allocated
egress_done_i  input  NUM_PORTS x 1  pulse from TX path j: frame fully transmitted
protocol_err_o  output  1  sticky protocol-error flag

Behaviour:
- Reset values: all outputs 0, all egress free, RR pointer 0, wait counters 0, no reservation. Reset mid-frame abandons all allocations with no done required.
- Requester contract:
  - req_valid_i and req_dst_mask_i stay stable from assertion until grant_o.
  - Deasserting valid before grant withdraws the request; its wait counter clears.
- Effective mask = req_dst_mask_i[i] with bit i cleared. No hairpin forwarding.
- Eligibility of ingress i, evaluated on registered state only:
  - valid;
  - (effective mask AND busy) == 0;
  - (effective mask AND reserved mask) == 0, unless i is the reservation owner.
  - An empty effective mask is always eligible.
- Arbitration: at most one grant per cycle. Scan starts at the RR pointer; the first eligible i wins.
- Grant registers (latency 1: a request eligible in cycle N is granted at edge N+1):
  - grant_o[i] and grant_mask_o pulse;
  - busy set for every mask bit;
  - egress_start_o pulses for those bits;
  - egress_src_o loaded with i;
  - RR pointer = i+1 mod NUM_PORTS.
  - Empty-mask grant: grant_drop_o=1, no egress affected, pointer still advances.
- Release:
  - egress_done_i[j] clears busy[j] at the next edge.
  - egress_src_o[j] holds its last value.
  - A port freed at edge N becomes grantable in the arbitration evaluated during cycle N (grant at N+1). Done and a new grant never target the same port at the same edge.
- Aging:
  - Per-ingress wait counter increments each cycle the request is valid and not granted; saturates at MAX_WAIT.
  - Clears on grant or withdraw.
- Reservation:
  - When no reservation is held, the first counter at MAX_WAIT in RR order from the pointer becomes owner; its effective mask becomes the reserved mask.
  - Cleared on the owner's grant or withdraw.
  - Single owner at a time.
- protocol_err_o is set and held until reset on either:
  - egress_done_i[j] while busy[j]=0 (the done is otherwise ignored);
  - req_dst_mask_i changing while valid and ungranted.
- Widths: PORT_W = $clog2(NUM_PORTS); wait counter width = $clog2(MAX_WAIT+1).

Decomposition:
- Shared in switch_pkg:
  - NUM_PORTS and PORT_W;
  - port_mask_t (logic [NUM_PORTS-1:0]);
  - port_idx_t (logic [PORT_W-1:0]).
- One sub-module: rr_priority_pick.
  - Purely combinational.
  - Inputs: eligibility vector and pointer.
  - Outputs: winner index and found flag.
  - Reused for both grant selection and urgent-owner selection.

Test Plan:
- Unicast:
  - Stimulus: ingress 0 mask 0010 on an idle switch.
  - Response: grant_o[0] one cycle later, grant_mask_o=0010, egress_start_o[1], egress_src_o[1]=0.
  - After egress_done_i[1], busy[1] drops the next cycle.
- Flood and drop:
  - Stimulus: ingress 2 mask 1111.
  - Response: grant_mask_o=1011, egress 0, 1 and 3 busy.
  - Stimulus: ingress 3 mask 1000.
  - Response: grant_drop_o=1, no egress_start_o.
- Round-robin:
  - Stimulus: ingresses 0, 1 and 3 all request egress 2 continuously, each frame released by done 10 cycles later.
  - Response: grant order 0, 1, 3, 0, 1, 3.
- Starvation guard (MAX_WAIT=64):
  - Stimulus: ingress 0 floods while ingresses 1/2/3 keep ports busy with back-to-back unicasts.
  - Response: flood granted after at most 64 cycles plus the longest in-flight frame; no new unicast grant touching 1110 after the reservation forms.
- Protocol error:
  - Stimulus: done on an idle egress.
  - Response: protocol_err_o=1 and held; no state change.
- Reset mid-operation:
  - Stimulus: switch_rst with 3 egress ports busy and 2 requests pending.
  - Response: all outputs 0 immediately; requests re-arbitrate from pointer 0 after release.
